pipe_stage_buffer: RTL and testbench
====================================

# pipe_stage_buffer

Parametrised, handshaked pipeline stage register for the rv32i pipeline, generalising the fixed-field inter-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block. It carries an opaque WIDTH-bit payload (the packed stage bundle) with valid/ready flow control on both sides, a 2-entry skid so that `in_ready` is fully registered, and a synchronous flush that turns the stage into a bubble. One instance sits between every pair of pipeline stages; the stage logic packs and unpacks the payload.

## Interface
Parameters:
- WIDTH, 32: payload width in bits (the packed stage bundle).
- BUBBLE, '0 (WIDTH bits): payload presented when the stage is empty or flushed (encodes a NOP with rd = x0).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous kill of all held entries; highest priority.
- in_valid  in  1  upstream stage presents a payload.
- in_ready  out  1  buffer accepts; registered, no combinational path from out_ready.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data is a live instruction.
- out_ready  in  1  downstream stage consumes this cycle (0 = stall).
- out_data  out  WIDTH  head payload; equals BUBBLE whenever out_valid = 0.
- count  out  2  occupancy, 0..2.
- flushed_cnt  out  2  number of live entries discarded by the most recent flush; held until the next flush.

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: head entry (drives out_data) and skid entry.
- FSM states: EMPTY (count 0), ONE (head live), TWO (head and skid live).
- EMPTY: in_ready = 1. in_fire -> ONE, head <= in_data.
- ONE: in_ready = 1.
  - in_fire & out_fire -> ONE, head <= in_data.
  - in_fire & !out_ready -> TWO, skid <= in_data.
  - !in_fire & out_fire -> EMPTY, head <= BUBBLE.
  - Neither -> hold.
- TWO: in_ready = 0. out_fire -> ONE, head <= skid, skid <= BUBBLE. Otherwise hold.
- FIFO order is always preserved; the skid never bypasses the head.
- Flush (any state): next state EMPTY, head and skid <= BUBBLE, flushed_cnt <= count. Any in_fire and out_fire in the flush cycle are discarded. out_valid, count and flushed_cnt update on the same edge.
- Payload is never interpreted; width arithmetic is none. count is the state encoding, so it never wraps.

## Timing
- Latency: in_fire at edge N gives out_valid = 1 with that payload after edge N (one cycle), when the buffer is EMPTY or ONE with concurrent out_fire.
- Throughput: one transfer per cycle sustained with out_ready held at 1.
- Stall: out_ready = 0 for 2+ cycles. The buffer absorbs one extra entry, then in_ready falls after the edge that fills the skid.
- in_ready is a function of the state register only. Upstream may treat in_ready as valid at the start of each cycle.
- Reset (rst = 0, asynchronous):
  - state EMPTY; out_valid 0; in_ready 1; count 0; flushed_cnt 0; out_data = BUBBLE; skid = BUBBLE.
  - Reset asserted mid-transfer drops all entries with no partial update.
  - Deassertion is synchronised by the top level.
- Simultaneous flush and rst = 0: reset wins.

## Structure
- rv32i_types holds the stage-bundle typedefs (id_ex_bundle_t etc.) and their widths. The payload is packed and cast at the instantiating stage.
- rv32i_types also holds PIPE_BUBBLE constants per bundle, passed in as the BUBBLE parameter.
- FSM state enum (PSB_EMPTY, PSB_ONE, PSB_TWO) is local to the block.
- One natural sub-module: pipe_entry_reg, a WIDTH-bit register with async active-low reset to BUBBLE, load enable and synchronous clear. It is instantiated twice, for head and skid.

## Test plan
- Reset then streaming: rst low 2 cycles; in_data 0x11, 0x22, 0x33 with out_ready = 1 -> out_data 0x11, 0x22, 0x33 on consecutive cycles one cycle later; count never exceeds 1.
- Stall absorb: out_ready = 0 while 0xA1 and 0xA2 are sent -> count = 2, in_ready = 0. Hold 3 cycles -> 0xA1 stays on out_data. Release -> 0xA1, then 0xA2, then out_valid = 0 with out_data = BUBBLE.
- Flush in TWO: with 0xB1 and 0xB2 held, assert flush and in_valid with 0xB3 -> next cycle count = 0, out_valid = 0, flushed_cnt = 2, out_data = BUBBLE; 0xB3 never appears.
- Flush with concurrent out_fire in ONE -> head discarded, flushed_cnt = 1, no duplicate output.
- Async reset mid-stall: rst falls between edges while in TWO -> out_valid = 0 and in_ready = 1 immediately, before the next edge.
- Random valid/ready, 10k cycles, WIDTH = 64 -> scoreboard order and payload match; in_ready never depends on the same-cycle out_ready.

Source files
------------

// File: rtl/pipe_stage_buffer_pkg.sv
// Shared types for the handshaked pipeline stage buffer: FSM state encoding
// and the per-entry register control bundle.
package pipe_stage_buffer_pkg;

  // The state encoding doubles as the occupancy count, so count can never wrap.
  typedef enum logic [1:0] {
    PSB_EMPTY = 2'd0,
    PSB_ONE   = 2'd1,
    PSB_TWO   = 2'd2
  } psb_state_e;

  typedef struct packed {
    logic load;
    logic clr;
  } entry_ctrl_t;

  localparam entry_ctrl_t ENTRY_HOLD  = '{load: 1'b0, clr: 1'b0};
  localparam entry_ctrl_t ENTRY_LOAD  = '{load: 1'b1, clr: 1'b0};
  localparam entry_ctrl_t ENTRY_CLEAR = '{load: 1'b0, clr: 1'b1};

  function automatic logic [1:0] state_count(input psb_state_e s);
    return s;
  endfunction

endpackage

// File: rtl/pipe_stage_buffer_entry.sv
// One payload register (head or skid): async reset to BUBBLE, synchronous
// clear to BUBBLE (priority over load), and load enable.
module pipe_entry_reg
  import pipe_stage_buffer_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  entry_ctrl_t      ctrl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // NOTE: data_d is given its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    data_d = data_q;
    if (ctrl.clr) begin
      data_d = BUBBLE;
    end else if (ctrl.load) begin
      data_d = d;
    end
  end

  // NOTE: the payload register is reset (not left undefined like plain RAM) because out_data must read BUBBLE straight out of reset.
  // NOTE: sequential state is written with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= BUBBLE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Handshaked pipeline stage register with a 2-entry skid so in_ready depends
// only on the state register; flush turns the stage into a bubble.
module pipe_stage_buffer
  import pipe_stage_buffer_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count,
  output logic [1:0]       flushed_cnt
);

  psb_state_e       state_d, state_q;
  logic [1:0]       flushed_cnt_d, flushed_cnt_q;
  entry_ctrl_t      head_ctrl, skid_ctrl;
  logic [WIDTH-1:0] head_din;
  logic [WIDTH-1:0] head_q, skid_q;
  logic             in_fire, out_fire;

  assign in_ready  = (state_q != PSB_TWO);
  assign out_valid = (state_q != PSB_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = head_q;
  assign count     = state_count(state_q);
  assign flushed_cnt = flushed_cnt_q;

  always_comb begin
    state_d       = state_q;
    flushed_cnt_d = flushed_cnt_q;
    head_ctrl     = ENTRY_HOLD;
    skid_ctrl     = ENTRY_HOLD;
    head_din      = in_data;

    if (flush) begin
      // Any transfer in the flush cycle is discarded along with held entries.
      state_d       = PSB_EMPTY;
      flushed_cnt_d = state_count(state_q);
      head_ctrl     = ENTRY_CLEAR;
      skid_ctrl     = ENTRY_CLEAR;
    end else begin
      unique case (state_q)
        PSB_EMPTY: begin
          if (in_fire) begin
            state_d   = PSB_ONE;
            head_ctrl = ENTRY_LOAD;
          end
        end
        PSB_ONE: begin
          if (in_fire && out_fire) begin
            head_ctrl = ENTRY_LOAD;
          end else if (in_fire) begin
            state_d   = PSB_TWO;
            skid_ctrl = ENTRY_LOAD;
          end else if (out_fire) begin
            state_d   = PSB_EMPTY;
            head_ctrl = ENTRY_CLEAR;
          end
        end
        PSB_TWO: begin
          // Skid always drains through the head, preserving FIFO order.
          if (out_fire) begin
            state_d   = PSB_ONE;
            head_din  = skid_q;
            head_ctrl = ENTRY_LOAD;
            skid_ctrl = ENTRY_CLEAR;
          end
        end
        default: begin
          state_d   = PSB_EMPTY;
          head_ctrl = ENTRY_CLEAR;
          skid_ctrl = ENTRY_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= PSB_EMPTY;
      flushed_cnt_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      flushed_cnt_q <= flushed_cnt_d;
    end
  end

  pipe_entry_reg #(
    .WIDTH  (WIDTH),
    .BUBBLE (BUBBLE)
  ) u_head (
    .clk  (clk),
    .rst  (rst),
    .ctrl (head_ctrl),
    .d    (head_din),
    .q    (head_q)
  );

  pipe_entry_reg #(
    .WIDTH  (WIDTH),
    .BUBBLE (BUBBLE)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .ctrl (skid_ctrl),
    .d    (in_data),
    .q    (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer at WIDTH = 64 with a non-zero BUBBLE.
module tb_pipe_stage_buffer;

  localparam int          W      = 64;
  localparam logic [W-1:0] BUB   = 64'hDEAD_BEEF_0BAD_F00D;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   count;
  logic [1:0]   flushed_cnt;

  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_flushed;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_buffer #(
    .WIDTH  (W),
    .BUBBLE (BUB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .flushed_cnt (flushed_cnt)
  );

  // One clock cycle: scoreboard update from the current inputs, edge, then compare.
  task automatic tick();
    logic         m_ready;
    logic         in_fire_m;
    logic         out_fire_m;
    logic [W-1:0] exp;
    m_ready    = (exp_q.size() < 2);
    in_fire_m  = in_valid && m_ready;
    out_fire_m = out_ready && (exp_q.size() != 0);
    n_tests++;
    if (in_ready !== m_ready) begin
      n_fail++;
      $display("FAIL pre_in_ready: got %b expected %b", in_ready, m_ready);
    end
    if (flush) begin
      exp_flushed = 2'(exp_q.size());
      exp_q.delete();
    end else begin
      if (out_fire_m) begin
        exp = exp_q.pop_front();
        n_tests++;
        if (out_data !== exp) begin
          n_fail++;
          $display("FAIL sb_payload: got %h expected %h", out_data, exp);
        end
      end
      if (in_fire_m) exp_q.push_back(in_data);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (count !== 2'(exp_q.size()) || out_valid !== (exp_q.size() != 0)) begin
      n_fail++;
      $display("FAIL sb_occupancy: count %0d valid %b expected count %0d", count, out_valid, exp_q.size());
    end
    n_tests++;
    if (flushed_cnt !== exp_flushed) begin
      n_fail++;
      $display("FAIL sb_flushed_cnt: got %0d expected %0d", flushed_cnt, exp_flushed);
    end
    exp = (exp_q.size() == 0) ? BUB : exp_q[0];
    n_tests++;
    if (out_data !== exp) begin
      n_fail++;
      $display("FAIL sb_head: got %h expected %h", out_data, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    exp_flushed = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 2'd0 ||
        flushed_cnt !== 2'd0 || out_data !== BUB) begin
      n_fail++;
      $display("FAIL reset_state: valid %b ready %b count %0d fc %0d data %h", out_valid,
               in_ready, count, flushed_cnt, out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    logic [W-1:0] vals[3];
    vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== vals[i] || count > 2'd1) begin
        n_fail++;
        $display("FAIL stream_%0d: valid %b data %h count %0d expected data %h", i, out_valid,
                 out_data, count, vals[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stall_absorb();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA1; tick();
    in_data = 64'hA2; tick();
    in_valid = 1'b0;
    n_tests++;
    if (count !== 2'd2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_full: count %0d in_ready %b expected 2 and 0", count, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (out_data !== 64'hA1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got %h expected a1", i, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== BUB) begin
      n_fail++;
      $display("FAIL stall_drain: valid %b data %h expected 0 and bubble", out_valid, out_data);
    end
  endtask

  task automatic test_flush_two();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hB1; tick();
    in_data = 64'hB2; tick();
    flush = 1'b1; in_data = 64'hB3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (count !== 2'd0 || out_valid !== 1'b0 || flushed_cnt !== 2'd2 || out_data !== BUB) begin
      n_fail++;
      $display("FAIL flush_two: count %0d valid %b fc %0d data %h", count, out_valid,
               flushed_cnt, out_data);
    end
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_flush_one_out_fire();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'hC1; tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (flushed_cnt !== 2'd1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_one: fc %0d valid %b expected 1 and 0", flushed_cnt, out_valid);
    end
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hD1; tick();
    in_data = 64'hD2; tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 2'd0 || out_data !== BUB) begin
      n_fail++;
      $display("FAIL async_reset: valid %b ready %b count %0d data %h", out_valid, in_ready,
               count, out_data);
    end
    exp_q.delete();
    exp_flushed = 2'd0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic r;
    logic rdy0;
    for (int c = 0; c < 10000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = {$urandom(), $urandom()};
      flush    = ($urandom_range(0, 63) == 0);
      r        = ($urandom_range(0, 2) != 0);
      out_ready = ~r;
      #1;
      rdy0 = in_ready;
      out_ready = r;
      #1;
      n_tests++;
      if (in_ready !== rdy0) begin
        n_fail++;
        $display("FAIL ready_comb_path: in_ready %b changed to %b with out_ready", rdy0, in_ready);
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_absorb();
    test_flush_two();
    test_flush_one_out_fire();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
